// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drain stage for the 16-bit synchronous FIFO.
// Issues FIFO read strobes with credit-based flow control, absorbs the
// RAM read latency in a small skid buffer and presents the words as a
// valid/ready stream framed into fixed-length bursts (sop/eop).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   en                 read enable (in-flight words still drain when low)
//   fifo_empty         FIFO empty flag
//   fifo_rd_en         FIFO read strobe
//   fifo_rd_data       FIFO read data, valid RD_LAT cycles after strobe
//   m_valid/m_ready    output stream handshake
//   m_data             output word
//   m_sop/m_eop        first/last word of a burst (qualified by m_valid)
//   burst_cnt          completed bursts, wraps at 2^BCNT_W
//   busy               a word is in flight or buffered
`timescale 1ns/1ps

module fifo_burst_reader #(
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int BURST_LEN = 8,
    parameter int BCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic [BCNT_W-1:0] burst_cnt,
    output logic              busy
);

    localparam int DEPTH  = RD_LAT + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    // One spare bit so occ + inflight never overflows.
    localparam int CNT_W  = $clog2(DEPTH + 1) + 1;
    localparam int BEAT_W = $clog2(BURST_LEN);

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    // Skid buffer storage and control
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;

    // Strobe flags travelling alongside the RAM read latency
    logic [RD_LAT-1:0] pipe_q, pipe_d;

    // Burst framing
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    // Low during reset and the first cycle after release, so no
    // strobe is issued while rst_n is low or on the release edge.
    logic run_q, run_d;

    logic [CNT_W-1:0] inflight;
    logic             valid;
    logic             pop;
    logic             capture;
    logic             credit;
    logic             rd_en;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_q[i]);
        end
    end

    assign valid   = (occ_q != '0);
    assign pop     = valid & m_ready;
    assign capture = pipe_q[RD_LAT-1];

    // A pop in this cycle frees a slot, which keeps a 1 word/clk
    // stream going with m_ready held high.
    assign credit = (occ_q + inflight - CNT_W'(pop)) < DEPTH_C;
    assign rd_en  = run_q & en & ~fifo_empty & credit;

    always_comb begin
        run_d    = 1'b1;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        beat_d   = beat_q;
        bcnt_d   = bcnt_q;

        pipe_d[0] = rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (capture) begin
            mem_d[wr_ptr_q] = fifo_rd_data;
            if (wr_ptr_q == PTR_LAST) begin
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end

        if (pop) begin
            if (rd_ptr_q == PTR_LAST) begin
                rd_ptr_d = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (beat_q == BEAT_LAST) begin
                beat_d = '0;
                bcnt_d = bcnt_q + BCNT_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        unique case ({capture, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            pipe_q   <= '0;
            beat_q   <= '0;
            bcnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            run_q    <= run_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            pipe_q   <= pipe_d;
            beat_q   <= beat_d;
            bcnt_q   <= bcnt_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign m_valid    = valid;
    assign m_data     = mem_q[rd_ptr_q];
    assign m_sop      = valid & (beat_q == '0);
    assign m_eop      = valid & (beat_q == BEAT_LAST);
    assign burst_cnt  = bcnt_q;
    assign busy       = valid | (|pipe_q);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: u0 uses default
// parameters, u1 uses RD_LAT=2 and BCNT_W=4.
`timescale 1ns/1ps

module tb_fifo_burst_reader;

    logic clk;
    logic rst_n;
    logic        en [2];
    logic        fifo_empty [2];
    logic        fifo_rd_en [2];
    logic [15:0] rd_data [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [15:0] m_data [2];
    logic        m_sop [2];
    logic        m_eop [2];
    logic        busy [2];
    logic [15:0] bcnt0;
    logic [3:0]  bcnt1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_burst_reader u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]),
        .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
        .fifo_rd_data(rd_data[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_data(m_data[0]),
        .m_sop(m_sop[0]), .m_eop(m_eop[0]),
        .burst_cnt(bcnt0), .busy(busy[0])
    );

    fifo_burst_reader #(.RD_LAT(2), .BCNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]),
        .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
        .fifo_rd_data(rd_data[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_data(m_data[1]),
        .m_sop(m_sop[1]), .m_eop(m_eop[1]),
        .burst_cnt(bcnt1), .busy(busy[1])
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] fq0 [$];
    logic [15:0] fq1 [$];
    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];
    logic [15:0] p1;
    int   out_cnt [2];
    int   mb [2];
    int   mbc [2];
    int   npop [2];
    logic stl [2];
    logic rs [2];
    logic [15:0] sd [2];
    int   depth [2];
    int   bmod [2];
    int   last_bc1;
    logic saw_wrap;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        sop;
        logic        eop;
        logic        rd;
        logic        bz;
        logic [15:0] bc;
    } vec_t;

    vec_t tv [19];

    task automatic chk(input string nm, input int k,
                       input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    function automatic int exp_size(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic push(input int k, input logic [15:0] w);
        if (k == 0) begin
            fq0.push_back(w);
            exp0.push_back(w);
        end else begin
            fq1.push_back(w);
            exp1.push_back(w);
        end
        fifo_empty[k] = 1'b0;
    endtask

    task automatic clr();
        fq0.delete(); fq1.delete();
        exp0.delete(); exp1.delete();
        for (int k = 0; k < 2; k++) begin
            out_cnt[k] = 0; mb[k] = 0; mbc[k] = 0;
            stl[k] = 1'b0; rs[k] = 1'b0; sd[k] = '0;
            fifo_empty[k] = 1'b1;
        end
        last_bc1 = 0;
    endtask

    task automatic mon(input int k);
        logic        pop;
        logic [15:0] w;
        int          bc;
        bc = (k == 0) ? int'(bcnt0) : int'(bcnt1);
        if (!rst_n) begin
            rs[k] = 1'b0;
            return;
        end
        pop = m_valid[k] & m_ready[k];
        chk("burst_cnt", k, bc, mbc[k]);
        chk("busy", k, busy[k], out_cnt[k] != 0);
        chk("sop", k, m_sop[k], m_valid[k] && mb[k] == 0);
        chk("eop", k, m_eop[k], m_valid[k] && mb[k] == 7);
        if (stl[k]) begin
            chk("hold_valid", k, m_valid[k], 1);
            chk("hold_data", k, m_data[k], sd[k]);
        end
        if (pop) begin
            if (exp_size(k) == 0) begin
                chk("extra_word", k, exp_size(k), 1);
            end else begin
                w = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                chk("data", k, m_data[k], w);
            end
            npop[k]++;
            if (mb[k] == 7) begin
                mb[k] = 0;
                mbc[k] = (mbc[k] + 1) % bmod[k];
            end else begin
                mb[k]++;
            end
        end
        if (fifo_rd_en[k]) begin
            chk("rd_when_empty", k, fifo_empty[k], 0);
            chk("credit", k, out_cnt[k] + 1 - int'(pop) <= depth[k], 1);
        end
        if (k == 1) begin
            if (bc == 0 && last_bc1 == 15) saw_wrap = 1'b1;
            last_bc1 = bc;
        end
        out_cnt[k] += int'(fifo_rd_en[k]) - int'(pop);
        stl[k] = m_valid[k] & ~m_ready[k];
        sd[k]  = m_data[k];
        rs[k]  = fifo_rd_en[k];
    endtask

    task automatic fifo_step();
        if (rs[0]) rd_data[0] = (fq0.size() > 0) ? fq0.pop_front() : 16'hDEAD;
        fifo_empty[0] = (fq0.size() == 0);
        rd_data[1] = p1;
        if (rs[1]) p1 = (fq1.size() > 0) ? fq1.pop_front() : 16'hDEAD;
        fifo_empty[1] = (fq1.size() == 0);
    endtask

    task automatic cyc_a();
        @(negedge clk);
        mon(0);
        mon(1);
    endtask

    task automatic cyc_b();
        @(posedge clk);
        #1;
        fifo_step();
    endtask

    task automatic cyc();
        cyc_a();
        cyc_b();
    endtask

    task automatic drain(input int k, input int limit, input string nm);
        int n;
        n = 0;
        while ((exp_size(k) != 0 || busy[k]) && n < limit) begin
            cyc();
            n++;
        end
        chk({nm, "_left"}, k, exp_size(k), 0);
        chk({nm, "_busy"}, k, busy[k], 0);
    endtask

    task automatic chk_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_rd_en"}, k, fifo_rd_en[k], 0);
            chk({nm, "_valid"}, k, m_valid[k], 0);
            chk({nm, "_data"}, k, m_data[k], 0);
            chk({nm, "_sop"}, k, m_sop[k], 0);
            chk({nm, "_eop"}, k, m_eop[k], 0);
            chk({nm, "_busy"}, k, busy[k], 0);
        end
        chk({nm, "_bcnt"}, 0, bcnt0, 0);
        chk({nm, "_bcnt"}, 1, bcnt1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ns;
        int n;
        int base;

        depth[0] = 2; depth[1] = 3;
        bmod[0] = 65536; bmod[1] = 16;
        npop[0] = 0; npop[1] = 0;
        saw_wrap = 1'b0;
        p1 = '0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0; m_ready[k] = 1'b0; rd_data[k] = '0;
        end
        clr();

        // steady stream, cycle-by-cycle expected outputs of u0
        tv[0]  = '{1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        tv[1]  = '{1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        tv[2]  = '{1'b1, 16'd0,  1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
        tv[3]  = '{1'b1, 16'd1,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        tv[4]  = '{1'b1, 16'd2,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        tv[5]  = '{1'b1, 16'd3,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        tv[6]  = '{1'b1, 16'd4,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        tv[7]  = '{1'b1, 16'd5,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        tv[8]  = '{1'b1, 16'd6,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        tv[9]  = '{1'b1, 16'd7,  1'b0, 1'b1, 1'b1, 1'b1, 16'd0};
        tv[10] = '{1'b1, 16'd8,  1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
        tv[11] = '{1'b1, 16'd9,  1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
        tv[12] = '{1'b1, 16'd10, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
        tv[13] = '{1'b1, 16'd11, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
        tv[14] = '{1'b1, 16'd12, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
        tv[15] = '{1'b1, 16'd13, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
        tv[16] = '{1'b1, 16'd14, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
        tv[17] = '{1'b1, 16'd15, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
        tv[18] = '{1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (3) cyc();

        for (int i = 0; i < 16; i++) push(0, 16'(i));
        en[0] = 1'b1;
        m_ready[0] = 1'b1;
        for (int i = 0; i < 19; i++) begin
            cyc_a();
            chk("tv_valid", i, m_valid[0], tv[i].v);
            if (tv[i].v) chk("tv_data", i, m_data[0], tv[i].d);
            chk("tv_sop", i, m_sop[0], tv[i].sop);
            chk("tv_eop", i, m_eop[0], tv[i].eop);
            chk("tv_rd_en", i, fifo_rd_en[0], tv[i].rd);
            chk("tv_busy", i, busy[0], tv[i].bz);
            chk("tv_bcnt", i, bcnt0, tv[i].bc);
            cyc_b();
        end

        // backpressure on both latencies
        for (int i = 0; i < 16; i++) begin
            push(0, 16'h0100 + 16'(i));
            push(1, 16'h0200 + 16'(i));
        end
        en[1] = 1'b1;
        n = 0;
        while ((exp_size(0) != 0 || exp_size(1) != 0 ||
                busy[0] || busy[1]) && n < 200) begin
            m_ready[0] = (n < 16) ? (n % 2 == 0) : ((n - 16) % 6 == 5);
            m_ready[1] = m_ready[0];
            cyc();
            n++;
        end
        chk("bp_left", 0, exp_size(0), 0);
        chk("bp_left", 1, exp_size(1), 0);
        chk("bp_bcnt", 0, bcnt0, 4);
        chk("bp_bcnt", 1, bcnt1, 2);
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        en[1] = 1'b0;

        // empty gap inside one burst
        for (int i = 0; i < 3; i++) push(0, 16'h0300 + 16'(i));
        repeat (6) cyc();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("gap_rd_en", 0, fifo_rd_en[0], 0);
            chk("gap_eop", 0, m_eop[0], 0);
            chk("gap_busy", 0, busy[0], 0);
        end
        for (int i = 0; i < 5; i++) push(0, 16'h0303 + 16'(i));
        drain(0, 40, "gap");
        chk("gap_bcnt", 0, bcnt0, 5);

        // en dropped after 4 strobes
        en[0] = 1'b0;
        for (int i = 0; i < 12; i++) push(0, 16'h0400 + 16'(i));
        base = npop[0];
        en[0] = 1'b1;
        ns = 0;
        n = 0;
        while (ns < 4 && n < 20) begin
            cyc();
            if (rs[0]) ns++;
            n++;
        end
        en[0] = 1'b0;
        chk("en_strobes", 0, ns, 4);
        n = 0;
        while (busy[0] && n < 20) begin
            cyc();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("en_off_rd", 0, fifo_rd_en[0], 0);
        end
        chk("en_off_words", 0, npop[0] - base, 4);
        chk("en_off_fifo", 0, fq0.size(), 8);
        en[0] = 1'b1;
        drain(0, 40, "en_on");
        chk("en_on_words", 0, npop[0] - base, 12);
        chk("en_on_bcnt", 0, bcnt0, 6);

        // reset with words buffered and in flight on u1
        for (int i = 0; i < 6; i++) push(1, 16'h0500 + 16'(i));
        m_ready[1] = 1'b0;
        en[1] = 1'b1;
        repeat (4) cyc();
        chk("pre_rst_valid", 1, m_valid[1], 1);
        chk("pre_rst_busy", 1, busy[1], 1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        clr();
        en[0] = 1'b0;
        en[1] = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) push(1, 16'h0600 + 16'(i));
        en[1] = 1'b1;
        m_ready[1] = 1'b1;
        drain(1, 60, "post_rst");
        chk("post_rst_bcnt", 1, bcnt1, 1);

        // 16 more bursts: 4-bit counter passes 15 -> 0 -> 1
        saw_wrap = 1'b0;
        for (int i = 0; i < 128; i++) push(1, 16'(i) ^ 16'h5A5A);
        drain(1, 400, "wrap");
        chk("wrap_bcnt", 1, bcnt1, 1);
        chk("wrap_seen", 1, saw_wrap, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
